// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the multi-port integer register file.
//   DEF_XLEN   default data width in bits
//   DEF_NREGS  default number of architectural registers (power of two, >= 4)
//   DEF_NRD    default number of combinational read ports (1..4)
//   rf_state_t clear-sweep FSM state encoding
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int DEF_XLEN  = 64;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;

    typedef enum logic {
        IDLE,
        CLEAR
    } rf_state_t;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Per-register pending bits that track in-flight producers.
//   clk, reset_n   clock and asynchronous active-low reset
//   wr_en/wr_addr  write ports 0 and 1, already gated off during a sweep
//   alloc_en/addr  destination being issued, already gated off during a sweep
//   clr_en/clr_idx clear-sweep slot whose pending bit is zeroed this cycle
//   rd_addr        read-port addresses
//   rd_ready       per read port: no pending producer, or being written now
// ---------------------------------------------------------------------------
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        wr_en,
    input  logic [2*AW-1:0]   wr_addr,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_idx,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_ready
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pendingNext;

    // Later assignments win: write clears, an alloc re-sets it (the newly
    // issued producer is still outstanding), and the sweep clears last.
    always_comb begin : pendingUpdate
        // NOTE: the default on the first line keeps this a pure combinational
        // block; any path that skips an assignment would otherwise infer a latch.
        pendingNext = pending;
        for (int r = 1; r < NREGS; r++) begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] == r[AW-1:0])) begin
                    pendingNext[r] = 1'b0;
                end
            end
            if (alloc_en && (alloc_addr == r[AW-1:0])) begin
                pendingNext[r] = 1'b1;
            end
            if (clr_en && (clr_idx == r[AW-1:0])) begin
                pendingNext[r] = 1'b0;
            end
        end
        pendingNext[0] = 1'b0;
    end

    // NOTE: state elements use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    always_comb begin : readyGen
        logic [AW-1:0] a;
        logic          wrHit;
        rd_ready = '0;
        for (int i = 0; i < NRD; i++) begin
            a     = rd_addr[i*AW +: AW];
            wrHit = (wr_en[0] && (wr_addr[0 +: AW]  == a)) ||
                    (wr_en[1] && (wr_addr[AW +: AW] == a));
            rd_ready[i] = !pending[a] || wrHit;
        end
    end

endmodule : rf_scoreboard

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
// Multi-port integer register file: NRD combinational read ports with
// same-cycle write bypass, two write ports (port 1 has priority), a pending
// scoreboard and a sequenced clear sweep. Register 0 always reads zero.
//   clk, reset_n   clock and asynchronous active-low reset
//   rd_addr        NRD read addresses, port i at [i*AW +: AW]
//   rd_data        NRD read data, port i at [i*XLEN +: XLEN]
//   rd_ready       per read port operand valid
//   wr_en/addr/data write ports 0 and 1
//   alloc_en/addr  mark a destination register pending
//   clear_req      start a clear sweep (sampled in IDLE only)
//   clear_busy     high while the sweep runs
// ---------------------------------------------------------------------------
module register_file_mp
    import rf_pkg::*;
#(
    parameter  int XLEN  = DEF_XLEN,
    parameter  int NREGS = DEF_NREGS,
    parameter  int NRD   = DEF_NRD,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_ready,
    input  logic [1:0]          wr_en,
    input  logic [2*AW-1:0]     wr_addr,
    input  logic [2*XLEN-1:0]   wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                clear_req,
    output logic                clear_busy
);

    rf_state_t        state, stateNext;
    logic [AW-1:0]    clrIdx, clrIdxNext;
    logic             clearing;
    logic [1:0]       wrEnEff;
    logic             allocEff;
    logic [NRD-1:0]   sbReady;
    logic [XLEN-1:0]  regs [NREGS];

    // ---------------- clear FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            clrIdx <= '0;
        end else begin
            state  <= stateNext;
            clrIdx <= clrIdxNext;
        end
    end

    // ---------------- clear FSM: next state ----------------
    // The sweep starts at 1 (register 0 is already zero) and stops after
    // clearing NREGS-1, so the index never wraps.
    always_comb begin
        stateNext  = state;
        clrIdxNext = clrIdx;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    stateNext  = CLEAR;
                    clrIdxNext = AW'(1);
                end
            end
            CLEAR: begin
                if (clrIdx == AW'(NREGS - 1)) begin
                    stateNext  = IDLE;
                    clrIdxNext = '0;
                end else begin
                    clrIdxNext = clrIdx + AW'(1);
                end
            end
            default: begin
                stateNext  = IDLE;
                clrIdxNext = '0;
            end
        endcase
    end

    // ---------------- clear FSM: outputs ----------------
    always_comb begin
        clearing   = (state == CLEAR);
        clear_busy = clearing;
        wrEnEff    = clearing ? 2'b00 : wr_en;
        allocEff   = alloc_en && !clearing;
    end

    // ---------------- storage ----------------
    // NOTE: the array is reset explicitly because the clear-on-reset behaviour
    // is architectural here; this costs a reset net on every storage flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            regs[0] <= '0;
            for (int r = 1; r < NREGS; r++) begin
                if (clearing && (clrIdx == r[AW-1:0])) begin
                    regs[r] <= '0;
                end else if (wrEnEff[1] && (wr_addr[AW +: AW] == r[AW-1:0])) begin
                    regs[r] <= wr_data[XLEN +: XLEN];
                end else if (wrEnEff[0] && (wr_addr[0 +: AW] == r[AW-1:0])) begin
                    regs[r] <= wr_data[0 +: XLEN];
                end
            end
        end
    end

    // ---------------- read ports with bypass ----------------
    // Priority, lowest to highest: storage, port 0 bypass, port 1 bypass,
    // x0 forced zero, sweep forced zero.
    always_comb begin : readMux
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            a = rd_addr[i*AW +: AW];
            v = regs[a];
            if (wrEnEff[0] && (wr_addr[0 +: AW] == a)) begin
                v = wr_data[0 +: XLEN];
            end
            if (wrEnEff[1] && (wr_addr[AW +: AW] == a)) begin
                v = wr_data[XLEN +: XLEN];
            end
            if ((a == '0) || clearing) begin
                v = '0;
            end
            rd_data[i*XLEN +: XLEN] = v;
        end
    end

    // ---------------- scoreboard ----------------
    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) uScoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wrEnEff),
        .wr_addr    (wr_addr),
        .alloc_en   (allocEff),
        .alloc_addr (alloc_addr),
        .clr_en     (clearing),
        .clr_idx    (clrIdx),
        .rd_addr    (rd_addr),
        .rd_ready   (sbReady)
    );

    assign rd_ready = clearing ? '0 : sbReady;

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
// ---------------------------------------------------------------------------
// tb_register_file_mp
// Directed testbench for register_file_mp with default parameters
// (XLEN=64, NREGS=32, NRD=2). Inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_register_file_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                reset_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_ready;
    logic [1:0]          wr_en;
    logic [2*AW-1:0]     wr_addr;
    logic [2*XLEN-1:0]   wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                clear_req;
    logic                clear_busy;

    int nCompared;
    int nMismatch;

    register_file_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .clear_req  (clear_req),
        .clear_busy (clear_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic setRead(input int a0, input int a1);
        rd_addr = {a1[AW-1:0], a0[AW-1:0]};
    endtask

    task automatic setWrite(input logic [1:0] en, input int a0, input logic [63:0] d0,
                            input int a1, input logic [63:0] d1);
        wr_en   = en;
        wr_addr = {a1[AW-1:0], a0[AW-1:0]};
        wr_data = {d1, d0};
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] fillVal(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [63:0] rd0();
        return rd_data[0 +: XLEN];
    endfunction

    function automatic logic [63:0] rd1();
        return rd_data[XLEN +: XLEN];
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int  cnt;
        bit  done;

        nCompared  = 0;
        nMismatch  = 0;
        reset_n    = 1'b0;
        rd_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        clear_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // ---- reset state ----
        setRead(5, 0);
        @(negedge clk);
        checkVal("reset_rd0_x5", rd0(), 64'h0);
        checkVal("reset_rd1_x0", rd1(), 64'h0);
        checkVal("reset_ready", 64'(rd_ready), 64'h3);
        checkVal("reset_busy", 64'(clear_busy), 64'h0);

        // ---- dual write same address: port 1 wins in bypass and storage ----
        nextCycle();
        setWrite(2'b11, 7, 64'h11, 7, 64'h22);
        setRead(7, 0);
        @(negedge clk);
        checkVal("bypass_p1_wins", rd0(), 64'h22);
        checkVal("bypass_ready", 64'(rd_ready), 64'h3);
        nextCycle();
        setWrite(2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checkVal("store_p1_wins", rd0(), 64'h22);

        // ---- x0 writes and allocs are ignored ----
        nextCycle();
        setWrite(2'b01, 0, 64'hFFFF, 0, 0);
        setRead(0, 0);
        @(negedge clk);
        checkVal("x0_bypass", rd0(), 64'h0);
        nextCycle();
        setWrite(2'b00, 0, 0, 0, 0);
        alloc_en   = 1'b1;
        alloc_addr = 5'd0;
        @(negedge clk);
        checkVal("x0_store", rd0(), 64'h0);
        nextCycle();
        alloc_en = 1'b0;
        @(negedge clk);
        checkVal("x0_alloc_ready", 64'(rd_ready[0]), 64'h1);

        // ---- alloc x3, ready drops next cycle, write restores via bypass ----
        nextCycle();
        alloc_en   = 1'b1;
        alloc_addr = 5'd3;
        setRead(3, 7);
        @(negedge clk);
        checkVal("x3_ready_issue_cycle", 64'(rd_ready[0]), 64'h1);
        nextCycle();
        alloc_en = 1'b0;
        @(negedge clk);
        checkVal("x3_ready_pending", 64'(rd_ready), 64'h2);
        nextCycle();
        setWrite(2'b01, 3, 64'hAB, 0, 0);
        @(negedge clk);
        checkVal("x3_ready_on_write", 64'(rd_ready[0]), 64'h1);
        checkVal("x3_bypass", rd0(), 64'hAB);
        nextCycle();
        setWrite(2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checkVal("x3_ready_after", 64'(rd_ready[0]), 64'h1);
        checkVal("x3_store", rd0(), 64'hAB);

        // ---- same-cycle alloc and write to x4: alloc wins ----
        nextCycle();
        alloc_en   = 1'b1;
        alloc_addr = 5'd4;
        setWrite(2'b01, 4, 64'h44, 0, 0);
        setRead(4, 3);
        @(negedge clk);
        checkVal("x4_ready_same_cycle", 64'(rd_ready[0]), 64'h1);
        nextCycle();
        alloc_en = 1'b0;
        setWrite(2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checkVal("x4_alloc_wins", 64'(rd_ready), 64'h2);
        checkVal("x4_store", rd0(), 64'h44);

        // ---- independent addresses on both write ports ----
        nextCycle();
        setWrite(2'b11, 8, 64'h88, 9, 64'h99);
        setRead(8, 9);
        @(negedge clk);
        checkVal("dual_bypass_p0", rd0(), 64'h88);
        checkVal("dual_bypass_p1", rd1(), 64'h99);

        // ---- fill x1..x31 ----
        for (int i = 1; i < NREGS; i += 2) begin
            nextCycle();
            if (i + 1 < NREGS) setWrite(2'b11, i, fillVal(i), i + 1, fillVal(i + 1));
            else               setWrite(2'b01, i, fillVal(i), 0, 0);
        end
        nextCycle();
        setWrite(2'b00, 0, 0, 0, 0);
        alloc_en   = 1'b1;
        alloc_addr = 5'd5;
        nextCycle();
        alloc_en = 1'b0;
        setRead(5, 31);
        @(negedge clk);
        checkVal("fill_rd_x5", rd0(), fillVal(5));
        checkVal("fill_rd_x31", rd1(), fillVal(31));
        checkVal("fill_ready", 64'(rd_ready), 64'h2);

        // ---- clear sweep ----
        nextCycle();
        clear_req = 1'b1;
        setRead(20, 1);
        @(negedge clk);
        checkVal("busy_low_on_req", 64'(clear_busy), 64'h0);
        nextCycle();
        clear_req  = 1'b0;
        setWrite(2'b11, 1, 64'hDEAD, 2, 64'hBEEF);
        alloc_en   = 1'b1;
        alloc_addr = 5'd1;
        cnt  = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (!clear_busy) begin
                done = 1'b1;
            end else begin
                cnt++;
                if (cnt == 1) begin
                    checkVal("sweep_rd_forced", rd0(), 64'h0);
                    checkVal("sweep_ready_forced", 64'(rd_ready), 64'h0);
                end
                @(posedge clk);
                #1;
                if (cnt >= 5) begin
                    setWrite(2'b00, 0, 0, 0, 0);
                    alloc_en = 1'b0;
                end
                clear_req = (cnt == 8);
            end
        end
        checkVal("sweep_done", 64'(done), 64'h1);
        checkVal("sweep_busy_cycles", 64'(cnt), 64'd31);

        // first cycle with clear_busy low accepts a write
        setWrite(2'b01, 6, 64'h66, 0, 0);
        setRead(6, 1);
        #1;
        checkVal("post_first_bypass", rd0(), 64'h66);
        nextCycle();
        setWrite(2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checkVal("post_first_store", rd0(), 64'h66);

        for (int i = 0; i < NREGS; i += 2) begin
            setRead(i, i + 1);
            #1;
            checkVal($sformatf("post_rd_x%0d", i), rd0(), (i == 6) ? 64'h66 : 64'h0);
            checkVal($sformatf("post_rd_x%0d", i + 1), rd1(), 64'h0);
            checkVal($sformatf("post_ready_x%0d", i), 64'(rd_ready), 64'h3);
        end

        // ---- reset during the sweep ----
        nextCycle();
        setWrite(2'b11, 3, 64'h33, 31, 64'h3131);
        nextCycle();
        setWrite(2'b00, 0, 0, 0, 0);
        setRead(3, 31);
        @(negedge clk);
        checkVal("pre_abort_x3", rd0(), 64'h33);
        checkVal("pre_abort_x31", rd1(), 64'h3131);
        nextCycle();
        clear_req = 1'b1;
        nextCycle();
        clear_req = 1'b0;
        cnt  = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (clear_busy) cnt++;
            if (cnt == 10) done = 1'b1;
        end
        checkVal("abort_reached_cycle10", 64'(cnt), 64'd10);
        reset_n = 1'b0;
        #1;
        checkVal("abort_busy_low", 64'(clear_busy), 64'h0);
        checkVal("abort_rd_x31", rd1(), 64'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        checkVal("abort_idle_busy", 64'(clear_busy), 64'h0);
        checkVal("abort_after_x3", rd0(), 64'h0);
        checkVal("abort_after_x31", rd1(), 64'h0);
        checkVal("abort_after_ready", 64'(rd_ready), 64'h3);
        nextCycle();
        setWrite(2'b01, 3, 64'h5A, 0, 0);
        nextCycle();
        setWrite(2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checkVal("abort_idle_write", rd0(), 64'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule : tb_register_file_mp
